axi_rd_line_assembler: RTL and testbench

// - Downstream of the AXI shim read-response path: sinks rd_valid/rd_data/rd_last/rd_id/rd_exokay

---
 rtl/ariane_axi.sv | 15 +
 rtl/axi_rd_line_assembler.sv | 106 ++++++++++
 tb/tb_axi_rd_line_assembler.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/ariane_axi.sv
// Shared read-path types: default line shape and the assembler FSM state encoding.
package ariane_axi;

  localparam int unsigned LineWords = 4;

  typedef logic [LineWords-1:0][63:0] line_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2,
    OUTPUT  = 2'd3
  } asm_state_t;

endpackage

// File: rtl/axi_rd_line_assembler.sv
// Packs one AXI read burst into a line; the line is valid the cycle after the last beat.
// Beats are back-pressured outside COLLECT/DRAIN; the finished line holds until line_ready_i.
module axi_rd_line_assembler
  import ariane_axi::*;
#(
  parameter int unsigned AxiNumWords = 4,
  parameter int unsigned AxiIdWidth  = 4,
  localparam int unsigned AddrIndex  = (AxiNumWords > 1) ? $clog2(AxiNumWords) : 1
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        cmd_valid_i,
  output logic                        cmd_ready_o,
  input  logic [AddrIndex-1:0]        cmd_blen_i,
  input  logic [AxiIdWidth-1:0]       cmd_id_i,
  input  logic                        rd_valid_i,
  output logic                        rd_rdy_o,
  input  logic [63:0]                 rd_data_i,
  input  logic                        rd_last_i,
  input  logic [AxiIdWidth-1:0]       rd_id_i,
  input  logic                        rd_exokay_i,
  output logic                        line_valid_o,
  input  logic                        line_ready_i,
  output logic [AxiNumWords*64-1:0]   line_data_o,
  output logic [AxiNumWords-1:0]      line_wvalid_o,
  output logic [AxiIdWidth-1:0]       line_id_o,
  output logic                        line_exokay_o,
  output logic                        line_err_o
);

  asm_state_t                    state_q;
  logic [AddrIndex-1:0]          beat_cnt_q;
  logic [AddrIndex-1:0]          blen_q;
  logic [AxiIdWidth-1:0]         id_q;
  logic [AxiNumWords-1:0][63:0]  line_q;
  logic [AxiNumWords-1:0]        mask_q;
  logic                          exokay_q;
  logic                          err_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      beat_cnt_q <= '0;
      blen_q     <= '0;
      id_q       <= '0;
      line_q     <= '0;
      mask_q     <= '0;
      exokay_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid_i) begin
            blen_q     <= cmd_blen_i;
            id_q       <= cmd_id_i;
            line_q     <= '0;
            mask_q     <= '0;
            exokay_q   <= 1'b1;
            err_q      <= 1'b0;
            beat_cnt_q <= '0;
            state_q    <= COLLECT;
          end
        end
        COLLECT: begin
          if (rd_valid_i) begin
            line_q[beat_cnt_q] <= rd_data_i;
            mask_q[beat_cnt_q] <= 1'b1;
            exokay_q           <= exokay_q & rd_exokay_i;
            // Short or long bursts are both flagged; the counter stops at blen so it never wraps.
            if (rd_last_i) begin
              err_q   <= err_q | (rd_id_i != id_q) | (beat_cnt_q != blen_q);
              state_q <= OUTPUT;
            end else if (beat_cnt_q == blen_q) begin
              err_q   <= 1'b1;
              state_q <= DRAIN;
            end else begin
              err_q      <= err_q | (rd_id_i != id_q);
              beat_cnt_q <= beat_cnt_q + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (rd_valid_i && rd_last_i) begin
            state_q <= OUTPUT;
          end
        end
        OUTPUT: begin
          if (line_ready_i) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready_o   = ~rst_i & (state_q == IDLE);
  assign rd_rdy_o      = ~rst_i & ((state_q == COLLECT) | (state_q == DRAIN));
  assign line_valid_o  = ~rst_i & (state_q == OUTPUT);
  assign line_data_o   = rst_i ? '0 : line_q;
  assign line_wvalid_o = rst_i ? '0 : mask_q;
  assign line_id_o     = rst_i ? '0 : id_q;
  assign line_exokay_o = ~rst_i & exokay_q;
  assign line_err_o    = ~rst_i & err_q;

endmodule

// File: tb/tb_axi_rd_line_assembler.sv
// Directed bench for axi_rd_line_assembler with a queue of expected lines.
module tb_axi_rd_line_assembler;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         cmd_valid_i;
  logic         cmd_ready_o;
  logic [1:0]   cmd_blen_i;
  logic [3:0]   cmd_id_i;
  logic         rd_valid_i;
  logic         rd_rdy_o;
  logic [63:0]  rd_data_i;
  logic         rd_last_i;
  logic [3:0]   rd_id_i;
  logic         rd_exokay_i;
  logic         line_valid_o;
  logic         line_ready_i;
  logic [255:0] line_data_o;
  logic [3:0]   line_wvalid_o;
  logic [3:0]   line_id_o;
  logic         line_exokay_o;
  logic         line_err_o;

  typedef struct {
    logic [255:0] data;
    logic [3:0]   wvalid;
    logic [3:0]   id;
    logic         exokay;
    logic         err;
  } exp_line_t;

  exp_line_t exp_q[$];
  int checks   = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  axi_rd_line_assembler #(.AxiNumWords(4), .AxiIdWidth(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_blen_i(cmd_blen_i), .cmd_id_i(cmd_id_i),
    .rd_valid_i(rd_valid_i), .rd_rdy_o(rd_rdy_o), .rd_data_i(rd_data_i),
    .rd_last_i(rd_last_i), .rd_id_i(rd_id_i), .rd_exokay_i(rd_exokay_i),
    .line_valid_o(line_valid_o), .line_ready_i(line_ready_i),
    .line_data_o(line_data_o), .line_wvalid_o(line_wvalid_o),
    .line_id_o(line_id_o), .line_exokay_o(line_exokay_o), .line_err_o(line_err_o)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [255:0] words(input logic [63:0] w0, input logic [63:0] w1,
                                         input logic [63:0] w2, input logic [63:0] w3);
    return {w3, w2, w1, w0};
  endfunction

  task automatic push_exp(input logic [255:0] d, input logic [3:0] wv, input logic [3:0] id,
                          input logic ex, input logic er);
    exp_line_t e;
    e.data = d; e.wvalid = wv; e.id = id; e.exokay = ex; e.err = er;
    exp_q.push_back(e);
  endtask

  task automatic arm(input logic [1:0] blen, input logic [3:0] id);
    int n = 0;
    while (cmd_ready_o !== 1'b1 && n < 50) begin tick(); n++; end
    chk("arm_ready", 256'(cmd_ready_o), 256'(1'b1));
    chk("arm_idle_rdrdy", 256'(rd_rdy_o), 256'(1'b0));
    cmd_valid_i = 1'b1; cmd_blen_i = blen; cmd_id_i = id;
    tick();
    cmd_valid_i = 1'b0;
  endtask

  task automatic beat(input logic [63:0] d, input logic last, input logic [3:0] id, input logic ex);
    int n = 0;
    rd_valid_i = 1'b1; rd_data_i = d; rd_last_i = last; rd_id_i = id; rd_exokay_i = ex;
    while (rd_rdy_o !== 1'b1 && n < 50) begin tick(); n++; end
    if (n == 50) chk("beat_timeout", 256'(rd_rdy_o), 256'(1'b1));
    tick();
    rd_valid_i = 1'b0; rd_last_i = 1'b0;
  endtask

  task automatic take_line(input string tag, input int hold);
    exp_line_t e;
    int n = 0;
    while (line_valid_o !== 1'b1 && n < 50) begin tick(); n++; end
    chk({tag, "_valid"}, 256'(line_valid_o), 256'(1'b1));
    if (exp_q.size() == 0) begin
      chk({tag, "_unexpected_line"}, 256'(exp_q.size()), 256'(1));
    end else begin
      e = exp_q.pop_front();
      for (int c = 0; c <= hold; c++) begin
        chk({tag, "_data"},   line_data_o,              e.data);
        chk({tag, "_wvalid"}, 256'(line_wvalid_o),      256'(e.wvalid));
        chk({tag, "_id"},     256'(line_id_o),          256'(e.id));
        chk({tag, "_exokay"}, 256'(line_exokay_o),      256'(e.exokay));
        chk({tag, "_err"},    256'(line_err_o),         256'(e.err));
        if (hold > 0) begin
          chk({tag, "_hold_valid"}, 256'(line_valid_o), 256'(1'b1));
          chk({tag, "_hold_rdrdy"}, 256'(rd_rdy_o),     256'(1'b0));
          chk({tag, "_hold_cmdrdy"}, 256'(cmd_ready_o), 256'(1'b0));
        end
        if (c < hold) tick();
      end
      line_ready_i = 1'b1;
      tick();
      line_ready_i = 1'b0;
      chk({tag, "_released"}, 256'(line_valid_o), 256'(1'b0));
    end
  endtask

  initial begin
    rst_i = 1'b1; cmd_valid_i = 1'b0; cmd_blen_i = '0; cmd_id_i = '0;
    rd_valid_i = 1'b0; rd_data_i = '0; rd_last_i = 1'b0; rd_id_i = '0; rd_exokay_i = 1'b0;
    line_ready_i = 1'b0;
    tick(); tick();
    chk("rst_cmd_ready", 256'(cmd_ready_o),  256'(1'b0));
    chk("rst_line_valid", 256'(line_valid_o), 256'(1'b0));
    chk("rst_data", line_data_o, 256'(0));
    rst_i = 1'b0;
    #1;
    chk("post_rst_ready", 256'(cmd_ready_o), 256'(1'b1));

    // Full burst, back-to-back beats
    arm(2'd3, 4'd2);
    push_exp(words(64'h11, 64'h22, 64'h33, 64'h44), 4'b1111, 4'd2, 1'b1, 1'b0);
    beat(64'h11, 1'b0, 4'd2, 1'b1);
    beat(64'h22, 1'b0, 4'd2, 1'b1);
    beat(64'h33, 1'b0, 4'd2, 1'b1);
    beat(64'h44, 1'b1, 4'd2, 1'b1);
    chk("full_latency", 256'(line_valid_o), 256'(1'b1));
    take_line("full", 0);

    // Single beat
    arm(2'd0, 4'd1);
    push_exp(words(64'hDEAD, 64'h0, 64'h0, 64'h0), 4'b0001, 4'd1, 1'b1, 1'b0);
    beat(64'hDEAD, 1'b1, 4'd1, 1'b1);
    chk("single_latency", 256'(line_valid_o), 256'(1'b1));
    take_line("single", 0);

    // Short burst: no drain
    arm(2'd3, 4'd4);
    push_exp(words(64'hAA, 64'hBB, 64'h0, 64'h0), 4'b0011, 4'd4, 1'b1, 1'b1);
    beat(64'hAA, 1'b0, 4'd4, 1'b1);
    beat(64'hBB, 1'b1, 4'd4, 1'b1);
    chk("short_no_drain", 256'(line_valid_o), 256'(1'b1));
    take_line("short", 0);

    // Long burst: third beat drained
    arm(2'd1, 4'd6);
    push_exp(words(64'hC1, 64'hC2, 64'h0, 64'h0), 4'b0011, 4'd6, 1'b1, 1'b1);
    beat(64'hC1, 1'b0, 4'd6, 1'b1);
    beat(64'hC2, 1'b0, 4'd6, 1'b1);
    chk("long_draining_rdy", 256'(rd_rdy_o), 256'(1'b1));
    chk("long_draining_nvalid", 256'(line_valid_o), 256'(1'b0));
    beat(64'hC3, 1'b1, 4'd6, 1'b1);
    take_line("long", 0);

    // ID mismatch + exokay=0, consumer stalls; stray beats and cmd ignored while held
    arm(2'd3, 4'd2);
    push_exp(words(64'h01, 64'h02, 64'h03, 64'h04), 4'b1111, 4'd2, 1'b0, 1'b1);
    beat(64'h01, 1'b0, 4'd2, 1'b1);
    beat(64'h02, 1'b0, 4'd5, 1'b0);
    beat(64'h03, 1'b0, 4'd2, 1'b1);
    beat(64'h04, 1'b1, 4'd2, 1'b1);
    rd_valid_i = 1'b1; rd_data_i = 64'hFF; rd_id_i = 4'd2;
    cmd_valid_i = 1'b1; cmd_id_i = 4'd9; cmd_blen_i = 2'd0;
    take_line("stall", 5);
    rd_valid_i = 1'b0; cmd_valid_i = 1'b0;

    // Reset mid-burst
    arm(2'd3, 4'd3);
    beat(64'h77, 1'b0, 4'd3, 1'b1);
    beat(64'h88, 1'b0, 4'd3, 1'b1);
    rst_i = 1'b1;
    #1;
    chk("midrst_rdrdy_gated", 256'(rd_rdy_o), 256'(1'b0));
    tick();
    rst_i = 1'b0;
    #1;
    chk("midrst_cmd_ready", 256'(cmd_ready_o),   256'(1'b1));
    chk("midrst_valid",     256'(line_valid_o),  256'(1'b0));
    chk("midrst_data",      line_data_o,         256'(0));
    chk("midrst_wvalid",    256'(line_wvalid_o), 256'(0));
    chk("midrst_err",       256'(line_err_o),    256'(0));
    chk("midrst_exokay",    256'(line_exokay_o), 256'(0));
    chk("midrst_id",        256'(line_id_o),     256'(0));
    chk("sb_empty",         256'(exp_q.size()),  256'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
